// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode/state types and op classification for seq_alu
package alu_pkg;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_AND = 3'b001,
    OP_XOR = 3'b010,
    OP_OR  = 3'b011,
    OP_SUB = 3'b100,
    OP_MUL = 3'b101,
    OP_DIV = 3'b110,
    OP_MOD = 3'b111
  } op_t;
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  function automatic logic is_iter_op(op_t o);
    return o == OP_MUL || o == OP_DIV || o == OP_MOD;
  endfunction
endpackage

// File: rtl/iter_muldiv.sv
// iter_muldiv: one-bit-per-step shift-add multiplier and restoring divider
module iter_muldiv #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  logic             r_div;
  logic [WIDTH-1:0] r_hi, r_lo, r_b;
  logic [WIDTH:0]   w_sum, w_t, w_diff;
  // o_hi/o_lo are the post-step values so the caller can capture the final step on the same edge
  always_comb begin
    w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_t    = {r_hi, r_lo[WIDTH-1]};
    w_diff = w_t - {1'b0, r_b};
    o_hi   = r_div ? (w_diff[WIDTH] ? w_t[WIDTH-1:0] : w_diff[WIDTH-1:0]) : w_sum[WIDTH:1];
    o_lo   = r_div ? {r_lo[WIDTH-2:0], ~w_diff[WIDTH]} : {w_sum[0], r_lo[WIDTH-1:1]};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div <= 1'b0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
    end else if (i_load) begin
      r_div <= i_div;
      r_hi  <= '0;
      r_lo  <= i_a;
      r_b   <= i_b;
    end else if (i_step) begin
      r_hi <= o_hi;
      r_lo <= o_lo;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with single-cycle logic/add/sub and iterative mul/div/mod
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             div0,
  output logic             busy
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  state_t           r_state;
  op_t              r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_y;
  logic             r_out_valid, r_zero, r_carry, r_ovf, r_div0;
  op_t              w_op;
  logic             w_accept, w_sub, w_arith, w_dz, w_go_iter, w_last, w_enter;
  logic             w_carry, w_ovf, w_div0;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_hi, w_lo, w_y;
  iter_muldiv #(.WIDTH(WIDTH)) u_md (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept && w_go_iter),
    .i_step (r_state == ITER),
    .i_div  (op[1]),
    .i_a    (a),
    .i_b    (b),
    .o_hi   (w_hi),
    .o_lo   (w_lo)
  );
  // Result/flags come from the live inputs on a single-cycle accept, or from the final muldiv step
  always_comb begin
    w_op      = op_t'(op);
    w_accept  = in_valid && r_state == IDLE;
    w_sub     = w_op == OP_SUB;
    w_arith   = w_sub || w_op == OP_ADD;
    w_dz      = (w_op == OP_DIV || w_op == OP_MOD) && b == '0;
    w_go_iter = is_iter_op(w_op) && !w_dz;
    w_last    = r_state == ITER && r_cnt == CNT_W'(1);
    w_enter   = w_last || (w_accept && !w_go_iter);
    w_sum     = {1'b0, a} + {1'b0, w_sub ? ~b : b} + {{WIDTH{1'b0}}, w_sub};
    w_y       = r_state == ITER ? (r_op == OP_MOD ? w_hi : w_lo)
              : w_dz ? (w_op == OP_MOD ? a : '1)
              : w_op == OP_AND ? a & b
              : w_op == OP_XOR ? a ^ b
              : w_op == OP_OR  ? a | b
              : w_sum[WIDTH-1:0];
    w_carry   = r_state != ITER && w_arith && w_sum[WIDTH];
    w_ovf     = r_state == ITER ? r_op == OP_MUL && |w_hi
              : w_arith && ((a[WIDTH-1] ^ b[WIDTH-1]) == w_sub) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    w_div0    = r_state != ITER && w_dz;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_op        <= OP_ADD;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_div0      <= 1'b0;
    end else begin
      if (w_enter) begin
        r_out_valid <= 1'b1;
        r_y         <= w_y;
        r_zero      <= w_y == '0;
        r_carry     <= w_carry;
        r_ovf       <= w_ovf;
        r_div0      <= w_div0;
      end else if (r_state == DONE && out_ready) begin
        r_out_valid <= 1'b0;
        r_y         <= '0;
        r_zero      <= 1'b0;
        r_carry     <= 1'b0;
        r_ovf       <= 1'b0;
        r_div0      <= 1'b0;
      end
      case (r_state)
        IDLE: if (w_accept) begin
          r_op    <= w_op;
          r_cnt   <= CNT_W'(WIDTH);
          r_state <= w_go_iter ? ITER : DONE;
        end
        ITER: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last) r_state <= DONE;
        end
        DONE: if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign in_ready  = r_state == IDLE;
  assign busy      = r_state == ITER;
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign zero      = r_zero;
  assign carry     = r_carry;
  assign ovf       = r_ovf;
  assign div0      = r_div0;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed-vector self-checking bench for seq_alu at WIDTH=12
module tb_seq_alu;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [11:0] a, b, y;
  logic [2:0]  op;
  logic        zero, carry, ovf, div0, busy;
  int          errors = 0;
  int          checks = 0;
  seq_alu #(.WIDTH(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .zero      (zero),
    .carry     (carry),
    .ovf       (ovf),
    .div0      (div0),
    .busy      (busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_op(input string tag, input logic [2:0] o, input logic [11:0] x, input logic [11:0] z,
                       input int el, input logic [11:0] ey, input logic ez, input logic ec,
                       input logic eo, input logic ed);
    int lat;
    chk({tag, " in_ready"}, in_ready, 1);
    in_valid = 1'b1; a = x; b = z; op = o;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 12'($urandom); b = 12'($urandom); op = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, el);
    chk({tag, " y"}, y, ey);
    chk({tag, " zero"}, zero, ez);
    chk({tag, " carry"}, carry, ec);
    chk({tag, " ovf"}, ovf, eo);
    chk({tag, " div0"}, div0, ed);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " cleared"}, {out_valid, y}, 13'h0);
    chk({tag, " idle"}, in_ready, 1);
  endtask
  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset busy", busy, 0);
    chk("reset flags", {y, zero, carry, ovf, div0}, 16'h0);
    //        tag        op     a       b       lat y       z  c  o  d
    do_op("add ovf",   3'd0, 12'h7FF, 12'h001, 1, 12'h800, 0, 0, 1, 0);
    do_op("add carry", 3'd0, 12'hFFF, 12'h001, 1, 12'h000, 1, 1, 0, 0);
    do_op("and",       3'd1, 12'hF0F, 12'h0FF, 1, 12'h00F, 0, 0, 0, 0);
    do_op("xor",       3'd2, 12'hF0F, 12'h0FF, 1, 12'hFF0, 0, 0, 0, 0);
    do_op("or",        3'd3, 12'hF00, 12'h00F, 1, 12'hF0F, 0, 0, 0, 0);
    do_op("sub neg",   3'd4, 12'h005, 12'h007, 1, 12'hFFE, 0, 0, 0, 0);
    do_op("sub eq",    3'd4, 12'h123, 12'h123, 1, 12'h000, 1, 1, 0, 0);
    do_op("sub ovf",   3'd4, 12'h800, 12'h001, 1, 12'h7FF, 0, 1, 1, 0);
    do_op("mul ovf",   3'd5, 12'h040, 12'h040, 13, 12'h000, 1, 0, 1, 0);
    do_op("mul",       3'd5, 12'h00C, 12'h00B, 13, 12'h084, 0, 0, 0, 0);
    do_op("mul max",   3'd5, 12'hFFF, 12'h001, 13, 12'hFFF, 0, 0, 0, 0);
    do_op("div",       3'd6, 12'h064, 12'h007, 13, 12'h00E, 0, 0, 0, 0);
    do_op("mod",       3'd7, 12'h064, 12'h007, 13, 12'h002, 0, 0, 0, 0);
    do_op("div small", 3'd6, 12'h003, 12'h00A, 13, 12'h000, 1, 0, 0, 0);
    do_op("div max",   3'd6, 12'hFFF, 12'h001, 13, 12'hFFF, 0, 0, 0, 0);
    do_op("mod big",   3'd7, 12'hFFF, 12'h800, 13, 12'h7FF, 0, 0, 0, 0);
    do_op("div by 0",  3'd6, 12'h055, 12'h000, 1, 12'hFFF, 0, 0, 0, 1);
    do_op("mod by 0",  3'd7, 12'h055, 12'h000, 1, 12'h055, 0, 0, 0, 1);
    do_op("mod 0 by 0", 3'd7, 12'h000, 12'h000, 1, 12'h000, 1, 0, 0, 1);
    // Backpressure: result held while a new op is offered and ignored
    in_valid = 1'b1; a = 12'h001; b = 12'h002; op = 3'd0;
    @(posedge clk); #1;
    a = 12'h0F0; b = 12'h00F; op = 3'd2;
    for (int i = 0; i < 5; i++) begin
      chk("bp hold", {out_valid, in_ready, y}, {2'b10, 12'h003});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp release", {out_valid, in_ready}, 2'b01);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp new op", {out_valid, y}, {1'b1, 12'h0FF});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    // Reset in the middle of a multiply
    in_valid = 1'b1; a = 12'h040; b = 12'h040; op = 3'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid reset", {out_valid, busy, in_ready, y}, {3'b001, 12'h000});
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen++;
    end
    chk("no stale result", seen, 0);
    do_op("mul after rst", 3'd5, 12'h00C, 12'h00B, 13, 12'h084, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
